// File: rtl/clkctrl_pkg.sv
// Shared types for the PHI2-stop clock switch: FSM states, switch target encoding, reset values.
// Pure declarations: no latency, no backpressure.
package clkctrl_pkg;

    typedef enum logic [1:0] {
        LS_RUN   = 2'd0,
        HOLD_HI  = 2'd1,
        WAIT_TGT = 2'd2,
        HS_RUN   = 2'd3
    } clk_state_t;

    typedef enum logic {
        TGT_LS = 1'b0,
        TGT_HS = 1'b1
    } clk_target_t;

    localparam clk_state_t  RST_STATE  = LS_RUN;
    localparam clk_target_t RST_TARGET = TGT_LS;
    localparam logic        RST_CLKOUT = 1'b0;

    function automatic logic is_switching(input clk_state_t s);
        return (s == HOLD_HI) || (s == WAIT_TGT);
    endfunction

endpackage

// File: rtl/clkctrl_delay_line.sv
// Host clock conditioning: synchroniser, tapped delay pipe, tap mux and edge detect.
// Latency SYNC_STAGES + i_delay_sel cycles to o_lsclk_del; no backpressure (free-running pipe).
module clkctrl_delay_line #(
    parameter int SYNC_STAGES = 2,
    parameter int DEL_W       = 2
) (
    input  logic             i_hsclk,
    input  logic             i_rst_b,
    input  logic             i_lsclk,
    input  logic [DEL_W-1:0] i_delay_sel,
    output logic             o_lsclk_del,
    output logic             o_lsclk_rise,
    output logic             o_lsclk_fall
);

    localparam int DEPTH = 2 ** DEL_W;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DEPTH-1:1]       r_pipe;
    logic                   r_del_prev;
    logic [DEPTH-1:0]       w_taps;
    logic                   w_lsclk_del;

    always_ff @(posedge i_hsclk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_sync     <= '0;
            r_pipe     <= '0;
            r_del_prev <= 1'b0;
        end else begin
            r_sync[0] <= i_lsclk;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_pipe[1] <= r_sync[SYNC_STAGES-1];
            for (int i = 2; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            r_del_prev <= w_lsclk_del;
        end
    end

    // Tap 0 is the synchroniser output itself, so the pipe only needs DEPTH-1 extra flops.
    assign w_taps      = {r_pipe, r_sync[SYNC_STAGES-1]};
    assign w_lsclk_del = w_taps[i_delay_sel];

    assign o_lsclk_del  = w_lsclk_del;
    assign o_lsclk_rise = ~r_del_prev & w_lsclk_del;
    assign o_lsclk_fall = r_del_prev & ~w_lsclk_del;

endmodule

// File: rtl/clkctrl_phi2_multi.sv
// Glitch-free CPU clock switch (host clock or divided hsclk), stopping in PHI2-high; clkout registered.
// Optional rdy clock stretch under CLKCTRL_RDY_STRETCH_EN; rdy is ignored when the macro is undefined.
module clkctrl_phi2_multi
    import clkctrl_pkg::*;
#(
    parameter int DIV_W       = 3,
    parameter int DEL_W       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HIGH    = 2
) (
    input  logic             hsclk_in,
    input  logic             rst_b,
    input  logic             lsclk_in,
    input  logic             hsclk_sel,
    input  logic [DIV_W-1:0] div_sel,
    input  logic [DEL_W-1:0] delay_sel,
    input  logic             rdy,
    output logic             clkout,
    output logic             hsclk_selected,
    output logic             lsclk_selected,
    output logic             switching
);

    localparam int MIN_W = (MIN_HIGH > 1) ? $clog2(MIN_HIGH) : 1;

    clk_state_t       r_state,     w_state_nxt;
    clk_target_t      r_target,    w_target_nxt;
    logic             r_clkout,    w_clkout_nxt;
    logic [DIV_W-1:0] r_phase_cnt, w_phase_nxt;
    logic [MIN_W-1:0] r_min_cnt,   w_min_nxt;
    logic             w_ls_hold;
    logic             w_hs_freeze;

    logic w_lsclk_del;
    logic w_lsclk_rise;
    logic w_lsclk_fall;

`ifdef CLKCTRL_RDY_STRETCH_EN
    logic r_stretch, w_stretch_nxt;
`else
    logic w_unused_rdy;
    assign w_unused_rdy = rdy;
`endif

    clkctrl_delay_line #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEL_W       (DEL_W)
    ) u_delay_line (
        .i_hsclk      (hsclk_in),
        .i_rst_b      (rst_b),
        .i_lsclk      (lsclk_in),
        .i_delay_sel  (delay_sel),
        .o_lsclk_del  (w_lsclk_del),
        .o_lsclk_rise (w_lsclk_rise),
        .o_lsclk_fall (w_lsclk_fall)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_clkout_nxt = r_clkout;
        w_phase_nxt  = r_phase_cnt;
        w_min_nxt    = r_min_cnt;
        w_ls_hold    = 1'b0;
        w_hs_freeze  = 1'b0;
`ifdef CLKCTRL_RDY_STRETCH_EN
        w_stretch_nxt = r_stretch;
        w_ls_hold     = r_clkout && (!rdy || r_stretch);
        w_hs_freeze   = r_clkout && !rdy;
`endif

        case (r_state)
            LS_RUN: begin
                if (w_ls_hold) begin
`ifdef CLKCTRL_RDY_STRETCH_EN
                    // A released stretch only ends on a real host-clock fall, never mid-phase.
                    if (rdy && w_lsclk_fall) begin
                        w_clkout_nxt  = 1'b0;
                        w_stretch_nxt = 1'b0;
                    end else begin
                        w_clkout_nxt  = 1'b1;
                        w_stretch_nxt = 1'b1;
                    end
`endif
                end else begin
                    w_clkout_nxt = w_lsclk_del;
                    if (hsclk_sel && w_lsclk_rise) begin
                        w_target_nxt = TGT_HS;
                        w_state_nxt  = HOLD_HI;
                        w_min_nxt    = '0;
                    end
                end
            end

            HS_RUN: begin
                if (!w_hs_freeze) begin
                    if (r_phase_cnt == '0) begin
                        if (!r_clkout && !hsclk_sel) begin
                            w_clkout_nxt = 1'b1;
                            w_target_nxt = TGT_LS;
                            w_state_nxt  = HOLD_HI;
                            w_min_nxt    = '0;
                        end else begin
                            w_clkout_nxt = ~r_clkout;
                            w_phase_nxt  = div_sel;
                        end
                    end else begin
                        w_phase_nxt = r_phase_cnt - DIV_W'(1);
                    end
                end
            end

            HOLD_HI: begin
                w_clkout_nxt = 1'b1;
                if (r_min_cnt == MIN_W'(MIN_HIGH - 1)) begin
                    w_state_nxt = WAIT_TGT;
                end else begin
                    w_min_nxt = r_min_cnt + MIN_W'(1);
                end
            end

            WAIT_TGT: begin
                w_clkout_nxt = 1'b1;
                if (r_target == TGT_HS) begin
                    w_clkout_nxt = 1'b0;
                    w_phase_nxt  = div_sel;
                    w_state_nxt  = HS_RUN;
                end else if (w_lsclk_fall) begin
                    w_clkout_nxt = 1'b0;
                    w_state_nxt  = LS_RUN;
                end
            end

            default: begin
                w_state_nxt  = RST_STATE;
                w_clkout_nxt = RST_CLKOUT;
            end
        endcase
    end

    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= RST_STATE;
            r_target    <= RST_TARGET;
            r_clkout    <= RST_CLKOUT;
            r_phase_cnt <= '0;
            r_min_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_target    <= w_target_nxt;
            r_clkout    <= w_clkout_nxt;
            r_phase_cnt <= w_phase_nxt;
            r_min_cnt   <= w_min_nxt;
        end
    end

`ifdef CLKCTRL_RDY_STRETCH_EN
    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            r_stretch <= 1'b0;
        end else begin
            r_stretch <= w_stretch_nxt;
        end
    end
`endif

    assign clkout         = r_clkout;
    assign hsclk_selected = (r_state == HS_RUN);
    assign lsclk_selected = (r_state == LS_RUN);
    assign switching      = is_switching(r_state);

endmodule

// File: tb/tb_clkctrl_phi2_multi.sv
// Bench for clkctrl_phi2_multi: host-clock latency model from sampled history, pulse-length rules in HS mode.
module tb_clkctrl_phi2_multi;

    localparam int DIV_W    = 3;
    localparam int DEL_W    = 2;
    localparam int SYNC     = 2;
    localparam int MIN_HIGH = 2;

    logic             hsclk_in  = 1'b0;
    logic             rst_b     = 1'b0;
    logic             lsclk_in  = 1'b0;
    logic             hsclk_sel = 1'b0;
    logic             rdy       = 1'b1;
    logic [DIV_W-1:0] div_sel   = 3'd1;
    logic [DEL_W-1:0] delay_sel = 2'd0;
    logic             clkout;
    logic             hsclk_selected;
    logic             lsclk_selected;
    logic             switching;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ls_half  = 8;
    int ls_cnt   = 0;
    bit ls_hist[$];
    int run_len[$];

    always #5 hsclk_in = ~hsclk_in;

    clkctrl_phi2_multi #(
        .DIV_W       (DIV_W),
        .DEL_W       (DEL_W),
        .SYNC_STAGES (SYNC),
        .MIN_HIGH    (MIN_HIGH)
    ) dut (
        .hsclk_in       (hsclk_in),
        .rst_b          (rst_b),
        .lsclk_in       (lsclk_in),
        .hsclk_sel      (hsclk_sel),
        .div_sel        (div_sel),
        .delay_sel      (delay_sel),
        .rdy            (rdy),
        .clkout         (clkout),
        .hsclk_selected (hsclk_selected),
        .lsclk_selected (lsclk_selected),
        .switching      (switching)
    );

    // Advance the host clock generator, record what the next edge samples, then step one hsclk cycle.
    task automatic tick();
        ls_cnt++;
        if (ls_cnt >= ls_half) begin
            lsclk_in = ~lsclk_in;
            ls_cnt   = 0;
        end
        ls_hist.push_back(lsclk_in);
        @(posedge hsclk_in);
        #1;
        cyc++;
    endtask

    // Host-clock value that should be on clkout now: sampled SYNC+d edges before the last edge.
    function automatic bit exp_ls(input int d);
        int i;
        i = cyc - 1 - SYNC - d;
        if (i < 0) return 1'b0;
        return ls_hist[i];
    endfunction

    task automatic measure_runs(input int n);
        bit prev;
        int len;
        run_len.delete();
        prev = clkout;
        len  = 1;
        repeat (n) begin
            tick();
            if (clkout == prev) len++;
            else begin
                run_len.push_back(len);
                prev = clkout;
                len  = 1;
            end
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (3) tick();
        checks++; if (clkout !== 1'b0)         begin failures++; $display("FAIL reset_clkout: got %b expected 0", clkout); end
        checks++; if (lsclk_selected !== 1'b1) begin failures++; $display("FAIL reset_lsclk_selected: got %b expected 1", lsclk_selected); end
        checks++; if (hsclk_selected !== 1'b0) begin failures++; $display("FAIL reset_hsclk_selected: got %b expected 0", hsclk_selected); end
        checks++; if (switching !== 1'b0)      begin failures++; $display("FAIL reset_switching: got %b expected 0", switching); end
    endtask

    task automatic test_ls_follow();
        int d;
        hsclk_sel = 1'b0;
        delay_sel = 2'd3;
        ls_half   = 8;
        rst_b     = 1'b1;
        d         = 3;
        for (int it = 0; it < 5; it++) begin
            if (it > 0) begin
                d         = $urandom_range(0, 3);
                ls_half   = $urandom_range(2, 9);
                delay_sel = DEL_W'(d);
            end
            repeat (30) tick();
            repeat (48) begin
                tick();
                checks++;
                if (clkout !== exp_ls(d)) begin
                    failures++;
                    $display("FAIL ls_follow d=%0d cyc=%0d: got %b expected %b", d, cyc, clkout, exp_ls(d));
                end
            end
            checks++; if (lsclk_selected !== 1'b1) begin failures++; $display("FAIL ls_selected: got %b expected 1", lsclk_selected); end
        end
    endtask

    task automatic test_hs_switch();
        int to, hi;
        ls_half   = 8;
        div_sel   = 3'd1;
        hsclk_sel = 1'b1;
        to = 0;
        while (switching !== 1'b1 && to < 100) begin tick(); to++; end
        checks++; if (to >= 100) begin failures++; $display("FAIL hs_switch_start: waited %0d cycles, required < 100", to); end
        checks++; if (clkout !== 1'b1) begin failures++; $display("FAIL hs_switch_entry_high: got %b expected 1", clkout); end
        hi = 0;
        while (clkout === 1'b1 && hi < 50) begin hi++; tick(); end
        checks++;
        if (hi < MIN_HIGH || hi > MIN_HIGH + 1) begin
            failures++; $display("FAIL hs_switch_hold_len: got %0d expected %0d..%0d", hi, MIN_HIGH, MIN_HIGH + 1);
        end
        checks++;
        if (hsclk_selected !== 1'b1 || switching !== 1'b0 || lsclk_selected !== 1'b0) begin
            failures++; $display("FAIL hs_switch_flags: got hs=%b sw=%b ls=%b expected 1 0 0", hsclk_selected, switching, lsclk_selected);
        end
        measure_runs(40);
        checks++; if (run_len.size() < 10) begin failures++; $display("FAIL hs_run_count: got %0d expected >= 10", run_len.size()); end
        foreach (run_len[i]) begin
            checks++;
            if (run_len[i] != 2) begin failures++; $display("FAIL hs_phase_len[%0d]: got %0d expected 2", i, run_len[i]); end
        end
    endtask

    task automatic test_div_change();
        int to, oldp, newp;
        bit prev;
        for (int it = 0; it < 4; it++) begin
            oldp = int'(div_sel) + 1;
            newp = (it == 0) ? 4 : $urandom_range(1, 8);
            to = 0;
            do begin prev = clkout; tick(); to++; end
            while (!(clkout === 1'b1 && prev === 1'b0) && to < 64);
            checks++; if (to >= 64) begin failures++; $display("FAIL div_wait_rise: waited %0d cycles, required < 64", to); end
            div_sel = DIV_W'(newp - 1);
            measure_runs(oldp + 6 * newp);
            checks++; if (run_len.size() < 4) begin failures++; $display("FAIL div_run_count: got %0d expected >= 4", run_len.size()); end
            foreach (run_len[i]) begin
                checks++;
                if (run_len[i] != ((i == 0) ? oldp : newp)) begin
                    failures++;
                    $display("FAIL div_phase_len[%0d] %0d->%0d: got %0d expected %0d", i, oldp, newp, run_len[i], (i == 0) ? oldp : newp);
                end
            end
        end
    endtask

    task automatic test_hs_to_ls();
        int to, len, minrun, seen;
        bit prev;
        div_sel   = 3'd1;
        delay_sel = 2'd2;
        ls_half   = 5;
        repeat (20) tick();
        hsclk_sel = 1'b0;
        prev = clkout; len = 1; minrun = 1000; seen = 0; to = 0;
        while (lsclk_selected !== 1'b1 && to < 200) begin
            tick(); to++;
            if (switching === 1'b1) begin
                checks++;
                if (clkout !== 1'b1 || hsclk_selected !== 1'b0) begin
                    failures++; $display("FAIL hs_to_ls_hold: got clkout=%b hs=%b expected 1 0", clkout, hsclk_selected);
                end
            end
            if (clkout == prev) len++;
            else begin
                if (seen > 0 && len < minrun) minrun = len;
                seen++; prev = clkout; len = 1;
            end
        end
        checks++; if (to >= 200) begin failures++; $display("FAIL hs_to_ls_timeout: waited %0d cycles, required < 200", to); end
        checks++; if (clkout !== 1'b0) begin failures++; $display("FAIL hs_to_ls_entry_low: got %b expected 0", clkout); end
        checks++;
        if (exp_ls(2) !== 1'b0 || ls_hist[cyc - 2 - SYNC - 2] !== 1'b1) begin
            failures++; $display("FAIL hs_to_ls_on_fall: got now=%b prev=%b expected 0 1", exp_ls(2), ls_hist[cyc - 2 - SYNC - 2]);
        end
        repeat (30) begin
            tick();
            checks++;
            if (clkout !== exp_ls(2)) begin failures++; $display("FAIL hs_to_ls_follow cyc=%0d: got %b expected %b", cyc, clkout, exp_ls(2)); end
            if (clkout == prev) len++;
            else begin
                if (seen > 0 && len < minrun) minrun = len;
                seen++; prev = clkout; len = 1;
            end
        end
        checks++; if (minrun < 2) begin failures++; $display("FAIL hs_to_ls_min_pulse: got %0d expected >= 2", minrun); end
    endtask

    task automatic test_reset_mid_switch();
        int to;
        hsclk_sel = 1'b1;
        to = 0;
        while (hsclk_selected !== 1'b1 && to < 200) begin tick(); to++; end
        checks++; if (to >= 200) begin failures++; $display("FAIL rst_mid_enter_hs: waited %0d cycles, required < 200", to); end
        ls_half = 30;
        to = 0;
        do begin tick(); to++; end while (!(lsclk_in === 1'b1 && ls_cnt == 0) && to < 100);
        hsclk_sel = 1'b0;
        to = 0;
        while (switching !== 1'b1 && to < 20) begin tick(); to++; end
        repeat (MIN_HIGH + 1) tick();
        checks++;
        if (switching !== 1'b1 || clkout !== 1'b1) begin
            failures++; $display("FAIL rst_mid_pre: got sw=%b clkout=%b expected 1 1", switching, clkout);
        end
        #2 rst_b = 1'b0;
        #1;
        checks++; if (clkout !== 1'b0)         begin failures++; $display("FAIL rst_mid_clkout: got %b expected 0", clkout); end
        checks++; if (lsclk_selected !== 1'b1) begin failures++; $display("FAIL rst_mid_lsclk_selected: got %b expected 1", lsclk_selected); end
        checks++; if (hsclk_selected !== 1'b0) begin failures++; $display("FAIL rst_mid_hsclk_selected: got %b expected 0", hsclk_selected); end
        checks++; if (switching !== 1'b0)      begin failures++; $display("FAIL rst_mid_switching: got %b expected 0", switching); end
        repeat (3) tick();
        rst_b   = 1'b1;
        ls_half = 4;
        repeat (3) tick();
    endtask

    task automatic test_rdy();
        int to, hi, exp_hi;
        bit prev;
`ifdef CLKCTRL_RDY_STRETCH_EN
        exp_hi = 6;
`else
        exp_hi = 1;
`endif
        div_sel   = 3'd0;
        hsclk_sel = 1'b1;
        to = 0;
        while (hsclk_selected !== 1'b1 && to < 200) begin tick(); to++; end
        checks++; if (to >= 200) begin failures++; $display("FAIL rdy_enter_hs: waited %0d cycles, required < 200", to); end
        repeat (4) tick();
        to = 0;
        do begin prev = clkout; tick(); to++; end
        while (!(clkout === 1'b1 && prev === 1'b0) && to < 64);
        checks++; if (to >= 64) begin failures++; $display("FAIL rdy_wait_rise: waited %0d cycles, required < 64", to); end
        rdy = 1'b0;
        hi  = 1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) rdy = 1'b1;
            tick();
            if (clkout !== 1'b1) break;
            hi++;
        end
        rdy = 1'b1;
        checks++; if (hi != exp_hi) begin failures++; $display("FAIL rdy_high_len: got %0d expected %0d", hi, exp_hi); end
        measure_runs(20);
        checks++; if (run_len.size() < 10) begin failures++; $display("FAIL rdy_run_count: got %0d expected >= 10", run_len.size()); end
        foreach (run_len[i]) begin
            checks++;
            if (run_len[i] != 1) begin failures++; $display("FAIL rdy_resume_len[%0d]: got %0d expected 1", i, run_len[i]); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ls_follow();
        test_hs_switch();
        test_div_change();
        test_hs_to_ls();
        test_reset_mid_switch();
        test_rdy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
